// File: rtl/subservient_dbg_loader_if.sv
// Wishbone write-initiator bundle between the image loader and the subservient debug port.
interface subservient_dbg_loader_if;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_ack_i;

   modport master (
      output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
      input  wbm_ack_i
   );

   modport slave (
      input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
      output wbm_ack_i
   );
endinterface

// File: rtl/subservient_dbg_loader.sv
// Packs a byte stream little-endian into words and writes them over Wishbone into the
// subservient SRAM while holding the core in debug mode.
module subservient_dbg_loader #(
   parameter int          MEMSIZE  = 1024,
   parameter logic [31:0] BASE_ADR = 32'h0000_0000,
   parameter int          TIMEOUT  = 255
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic                       i_start,
   input  logic [$clog2(MEMSIZE):0]   i_len,
   input  logic [7:0]                 i_byte,
   input  logic                       i_byte_valid,
   output logic                       o_byte_ready,
   subservient_dbg_loader_if.master   wbm,
   output logic                       o_debug_mode,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err
);

   localparam int LEN_W = $clog2(MEMSIZE) + 1;
   localparam int IDX_W = $clog2(MEMSIZE / 4);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] WRITE   = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   logic [1:0]       state;
   logic [LEN_W-1:0] remaining;
   logic [LEN_W-1:0] len_sat;
   logic [1:0]       lane;
   logic [3:0]       sel_q;
   logic [31:0]      word_q;
   logic [IDX_W-1:0] word_idx;
   logic [CNT_W-1:0] wait_cnt;
   logic             debug_q;
   logic             err_q;
   logic             cyc_act;
   logic             accept;
   logic             ack;

   assign len_sat = (i_len > LEN_W'(MEMSIZE)) ? LEN_W'(MEMSIZE) : i_len;
   assign accept  = (state == COLLECT) && i_byte_valid;
   assign ack     = (state == WRITE) && wbm.wbm_ack_i;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         remaining <= '0;
         lane      <= '0;
         sel_q     <= '0;
         word_idx  <= '0;
         wait_cnt  <= '0;
         debug_q   <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  err_q     <= 1'b0;
                  lane      <= '0;
                  sel_q     <= '0;
                  word_idx  <= '0;
                  remaining <= len_sat;
                  if (len_sat == '0) begin
                     state   <= DONE;
                     debug_q <= 1'b0;
                  end else begin
                     state   <= COLLECT;
                     debug_q <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (accept) begin
                  sel_q[lane] <= 1'b1;
                  lane        <= lane + 2'd1;
                  remaining   <= remaining - LEN_W'(1);
                  if (lane == 2'd3 || remaining == LEN_W'(1)) begin
                     state    <= WRITE;
                     wait_cnt <= '0;
                  end
               end
            end
            WRITE: begin
               if (ack) begin
                  sel_q    <= '0;
                  lane     <= '0;
                  word_idx <= word_idx + IDX_W'(1);
                  if (remaining == '0) begin
                     state   <= DONE;
                     debug_q <= 1'b0;
                  end else begin
                     state <= COLLECT;
                  end
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  // Give up on this write; the core stays in debug mode for a retry.
                  err_q <= 1'b1;
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Word register is cleared at load start and after each write so unwritten lanes read 0.
   always_ff @(posedge wb_clk_i) begin
      if ((state == IDLE && i_start) || ack)
         word_q <= '0;
      else if (accept)
         word_q[{lane, 3'b000} +: 8] <= i_byte;
   end

   // Bus is released combinationally while reset is asserted.
   assign cyc_act = (state == WRITE) && !wb_rst_i;

   assign wbm.wbm_cyc_o = cyc_act;
   assign wbm.wbm_stb_o = cyc_act;
   assign wbm.wbm_we_o  = cyc_act;
   assign wbm.wbm_adr_o = cyc_act ? (BASE_ADR + 32'({word_idx, 2'b00})) : 32'h0;
   assign wbm.wbm_dat_o = cyc_act ? word_q : 32'h0;
   assign wbm.wbm_sel_o = cyc_act ? sel_q : 4'h0;

   assign o_byte_ready = (state == COLLECT);
   assign o_busy       = (state == COLLECT) || (state == WRITE);
   assign o_done       = (state == DONE);
   assign o_debug_mode = debug_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_subservient_dbg_loader.sv
// Randomised bench for subservient_dbg_loader: a Wishbone responder records writes and
// each load is compared against a word-packing model of the byte image.
module tb_subservient_dbg_loader;

   localparam int          MEMSIZE  = 1024;
   localparam int          TIMEOUT  = 15;
   localparam logic [31:0] BASE_ADR = 32'h0000_0000;
   localparam int          LEN_W    = $clog2(MEMSIZE) + 1;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wr_t;

   logic             wb_clk_i = 1'b0;
   logic             wb_rst_i = 1'b1;
   logic             i_start = 1'b0;
   logic [LEN_W-1:0] i_len = '0;
   logic [7:0]       i_byte = '0;
   logic             i_byte_valid = 1'b0;
   logic             o_byte_ready, o_debug_mode, o_busy, o_done, o_err;

   subservient_dbg_loader_if wb ();

   subservient_dbg_loader #(
      .MEMSIZE (MEMSIZE),
      .BASE_ADR(BASE_ADR),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .i_start     (i_start),
      .i_len       (i_len),
      .i_byte      (i_byte),
      .i_byte_valid(i_byte_valid),
      .o_byte_ready(o_byte_ready),
      .wbm         (wb),
      .o_debug_mode(o_debug_mode),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int         n_cmp = 0;
   int         n_fail = 0;
   wr_t        got[$];
   wr_t        exp_q[$];
   logic [7:0] img[0:2047];
   int         resp_wait = 0;
   bit         resp_en = 1'b1;
   int         cyc_cycles = 0;
   int         done_cnt = 0;

   // Responder: acks after resp_wait wait states and checks the bus holds steady meanwhile.
   initial begin
      int  wcnt;
      wr_t cur, held;
      wcnt = 0;
      held = '0;
      wb.wbm_ack_i = 1'b0;
      forever begin
         @(negedge wb_clk_i);
         cur = {wb.wbm_adr_o, wb.wbm_dat_o, wb.wbm_sel_o};
         wb.wbm_ack_i = 1'b0;
         if (o_done) done_cnt++;
         if (wb.wbm_cyc_o) begin
            cyc_cycles++;
            n_cmp++;
            if (wb.wbm_stb_o !== 1'b1 || wb.wbm_we_o !== 1'b1) begin
               n_fail++;
               $display("FAIL wb_stb_we: stb=%b we=%b, required 1/1", wb.wbm_stb_o, wb.wbm_we_o);
            end
            if (wcnt == 0) held = cur;
            else begin
               n_cmp++;
               if (cur !== held) begin
                  n_fail++;
                  $display("FAIL wb_stable: bus %h changed from %h before ack", cur, held);
               end
            end
            if (resp_en && wcnt >= resp_wait) begin
               wb.wbm_ack_i = 1'b1;
               got.push_back(cur);
               wcnt = 0;
            end else wcnt++;
         end else wcnt = 0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) img[i] = 8'($urandom);
   endtask

   // Issues one load, streams the image and builds the expected write list.
   task automatic run_load(input int len, input int wt, input bit gaps, input bit en,
                           output int cycles);
      int n, idx;
      bit fin;
      n = (len > MEMSIZE) ? MEMSIZE : len;
      exp_q.delete();
      got.delete();
      for (int k = 0; 4 * k < n; k++) begin
         wr_t e;
         e.adr = BASE_ADR + 32'(4 * k);
         e.dat = '0;
         e.sel = '0;
         for (int b = 0; b < 4; b++)
            if (4 * k + b < n) begin
               e.dat[8*b +: 8] = img[4*k+b];
               e.sel[b] = 1'b1;
            end
         exp_q.push_back(e);
      end
      resp_wait = wt;
      resp_en = en;
      done_cnt = 0;
      cyc_cycles = 0;
      @(negedge wb_clk_i);
      i_len = LEN_W'(len);
      i_start = 1'b1;
      @(negedge wb_clk_i);
      i_start = 1'b0;
      cycles = 1;
      idx = 0;
      fin = 1'b0;
      while (!fin && cycles < 20000) begin
         if (o_done || o_err) fin = 1'b1;
         else begin
            if (idx < n && (!gaps || $urandom_range(3) != 0)) begin
               i_byte_valid = 1'b1;
               i_byte = img[idx];
            end else i_byte_valid = 1'b0;
            if (i_byte_valid && o_byte_ready) idx++;
            @(negedge wb_clk_i);
            cycles++;
         end
      end
      i_byte_valid = 1'b0;
      n_cmp++;
      if (!fin) begin
         n_fail++;
         $display("FAIL load_finish: no done/err after %0d cycles, required completion", cycles);
      end
      @(negedge wb_clk_i);
   endtask

   task automatic do_reset();
      wb_rst_i = 1'b1;
      repeat (3) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      repeat (5) @(negedge wb_clk_i);
      n_cmp += 6;
      if (o_debug_mode !== 1'b1) begin n_fail++; $display("FAIL reset_debug: %b, required 1", o_debug_mode); end
      if (wb.wbm_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: %b, required 0", wb.wbm_cyc_o); end
      if (wb.wbm_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_stb: %b, required 0", wb.wbm_stb_o); end
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b, required 0", o_busy); end
      if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: %b, required 0", o_err); end
      if (o_done !== 1'b0 || o_byte_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_done_ready: %b/%b, required 0/0", o_done, o_byte_ready);
      end
   endtask

   task automatic test_basic();
      int c;
      for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
      run_load(8, 1, 1'b0, 1'b1, c);
      n_cmp++;
      if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: %0d writes, required %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         wr_t g;
         g = (i < got.size()) ? got[i] : '0;
         n_cmp++;
         if (g !== exp_q[i]) begin n_fail++; $display("FAIL basic_write[%0d]: %h, required %h", i, g, exp_q[i]); end
      end
      n_cmp += 3;
      if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done: %0d pulses, required 1", done_cnt); end
      if (o_debug_mode !== 1'b0) begin n_fail++; $display("FAIL basic_debug: %b, required 0", o_debug_mode); end
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: %b, required 0", o_busy); end
   endtask

   task automatic test_partial();
      int c;
      wr_t want;
      for (int i = 0; i < 6; i++) img[i] = 8'(8'hAA + 8'(17 * i));
      run_load(6, int'($urandom_range(2)), 1'b1, 1'b1, c);
      want = {32'h4, 32'h0000_FFEE, 4'b0011};
      n_cmp++;
      if (got.size() != 2) begin n_fail++; $display("FAIL partial_count: %0d writes, required 2", got.size()); end
      else begin
         n_cmp++;
         if (got[1] !== want) begin n_fail++; $display("FAIL partial_last: %h, required %h", got[1], want); end
      end
      foreach (exp_q[i]) begin
         wr_t g;
         g = (i < got.size()) ? got[i] : '0;
         n_cmp++;
         if (g !== exp_q[i]) begin n_fail++; $display("FAIL partial_write[%0d]: %h, required %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_zero_len();
      int c;
      run_load(0, 0, 1'b0, 1'b1, c);
      n_cmp += 5;
      if (c != 1) begin n_fail++; $display("FAIL zero_latency: done after %0d cycles, required 1", c); end
      if (cyc_cycles != 0) begin n_fail++; $display("FAIL zero_bus: %0d cyc cycles, required 0", cyc_cycles); end
      if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done: %0d pulses, required 1", done_cnt); end
      if (o_debug_mode !== 1'b0) begin n_fail++; $display("FAIL zero_debug: %b, required 0", o_debug_mode); end
      if (o_err !== 1'b0) begin n_fail++; $display("FAIL zero_err: %b, required 0", o_err); end
   endtask

   task automatic test_back_to_back();
      int c;
      fill_random(8);
      run_load(8, 1, 1'b0, 1'b1, c);
      n_cmp++;
      if (c != 13) begin n_fail++; $display("FAIL b2b_cycles: done after %0d cycles, required 13", c); end
      foreach (exp_q[i]) begin
         wr_t g;
         g = (i < got.size()) ? got[i] : '0;
         n_cmp++;
         if (g !== exp_q[i]) begin n_fail++; $display("FAIL b2b_write[%0d]: %h, required %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_random();
      int c, len;
      for (int r = 0; r < 6; r++) begin
         len = int'($urandom_range(40, 1));
         fill_random(len);
         run_load(len, int'($urandom_range(3)), 1'b1, 1'b1, c);
         n_cmp += 2;
         if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count[%0d]: %0d writes, required %0d", r, got.size(), exp_q.size()); end
         if (done_cnt != 1) begin n_fail++; $display("FAIL rand_done[%0d]: %0d pulses, required 1", r, done_cnt); end
         foreach (exp_q[i]) begin
            wr_t g;
            g = (i < got.size()) ? got[i] : '0;
            n_cmp++;
            if (g !== exp_q[i]) begin n_fail++; $display("FAIL rand_write[%0d][%0d]: %h, required %h", r, i, g, exp_q[i]); end
         end
      end
   endtask

   task automatic test_timeout();
      int c;
      fill_random(4);
      run_load(4, 0, 1'b0, 1'b0, c);
      n_cmp += 5;
      if (cyc_cycles != TIMEOUT) begin n_fail++; $display("FAIL timeout_cyc: %0d cycles, required %0d", cyc_cycles, TIMEOUT); end
      if (o_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: %b, required 1", o_err); end
      if (o_debug_mode !== 1'b1) begin n_fail++; $display("FAIL timeout_debug: %b, required 1", o_debug_mode); end
      if (done_cnt != 0) begin n_fail++; $display("FAIL timeout_done: %0d pulses, required 0", done_cnt); end
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: %b, required 0", o_busy); end
   endtask

   task automatic test_saturate();
      int c;
      fill_random(MEMSIZE);
      run_load(2000, 0, 1'b0, 1'b1, c);
      n_cmp++;
      if (got.size() != 256) begin n_fail++; $display("FAIL sat_count: %0d writes, required 256", got.size()); end
      else begin
         n_cmp++;
         if (got[255].adr !== 32'h3FC) begin n_fail++; $display("FAIL sat_last_adr: %h, required 000003fc", got[255].adr); end
      end
      foreach (exp_q[i]) begin
         wr_t g;
         g = (i < got.size()) ? got[i] : '0;
         n_cmp++;
         if (g !== exp_q[i]) begin n_fail++; $display("FAIL sat_write[%0d]: %h, required %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_write();
      int  c, idx;
      bit  seen;
      fill_random(8);
      resp_wait = 10;
      resp_en = 1'b1;
      @(negedge wb_clk_i);
      i_len = LEN_W'(8);
      i_start = 1'b1;
      @(negedge wb_clk_i);
      i_start = 1'b0;
      seen = 1'b0;
      idx = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         if (wb.wbm_cyc_o) seen = 1'b1;
         else begin
            i_byte_valid = 1'b1;
            i_byte = img[idx];
            if (o_byte_ready) idx++;
            @(negedge wb_clk_i);
         end
      end
      i_byte_valid = 1'b0;
      n_cmp++;
      if (!seen) begin n_fail++; $display("FAIL midrst_reach: no write cycle seen, required one"); end
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      n_cmp += 4;
      if (wb.wbm_cyc_o !== 1'b0 || wb.wbm_stb_o !== 1'b0) begin
         n_fail++; $display("FAIL midrst_cyc: cyc/stb %b/%b, required 0/0", wb.wbm_cyc_o, wb.wbm_stb_o);
      end
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: %b, required 0", o_busy); end
      if (o_byte_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: %b, required 0", o_byte_ready); end
      if (o_debug_mode !== 1'b1) begin n_fail++; $display("FAIL midrst_debug: %b, required 1", o_debug_mode); end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      fill_random(2);
      run_load(2, 0, 1'b0, 1'b1, c);
      n_cmp++;
      if (got.size() != 1) begin n_fail++; $display("FAIL midrst_count: %0d writes, required 1", got.size()); end
      foreach (exp_q[i]) begin
         wr_t g;
         g = (i < got.size()) ? got[i] : '0;
         n_cmp++;
         if (g !== exp_q[i]) begin n_fail++; $display("FAIL midrst_write[%0d]: %h, required %h", i, g, exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_zero_len();
      test_back_to_back();
      test_random();
      test_timeout();
      test_zero_len();
      test_saturate();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
